// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port synchronous data SRAM between the core
// data port (d_*) and the host/debug port (h_*). Writes complete in the grant
// cycle; reads return one cycle later through RD_CORE / RD_HOST.
// Build macro DMEM_ARB_STAT_EN adds saturating wait-cycle counters
// (stat_core_wait, stat_host_wait) with a synchronous clear input stat_clr.

module dmem_arbiter #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned ARB_RR = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       d_addr,
  input  logic              d_wr_req,
  output logic              d_wr_ready,
  input  logic              d_rd_req,
  output logic              d_rd_ready,
  input  logic [3:0]        d_be,
  input  logic [31:0]       d_wr_data,
  output logic [31:0]       d_rd_data,
  input  logic              h_req,
  input  logic              h_we,
  input  logic [31:0]       h_addr,
  input  logic [3:0]        h_be,
  input  logic [31:0]       h_wdata,
  output logic              h_ready,
  output logic [31:0]       h_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [3:0]        m_be,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata
`ifdef DMEM_ARB_STAT_EN
  ,
  input  logic              stat_clr,
  output logic [15:0]       stat_core_wait,
  output logic [15:0]       stat_host_wait
`endif
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RD_CORE = 2'd1;
  localparam logic [1:0] S_RD_HOST = 2'd2;

  localparam logic GRANT_CORE = 1'b0;
  localparam logic GRANT_HOST = 1'b1;

  logic [1:0]  state_q, state_d;
  logic        last_grant_q;
  logic [31:0] d_rd_hold_q, h_rd_hold_q;

  logic core_cand, in_idle, grant_core, grant_host;
  logic rd_core_ret, rd_host_ret;

  // Byte offset and address bits above the SRAM depth are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{d_addr[31:ADDR_W+2], d_addr[1:0],
                              h_addr[31:ADDR_W+2], h_addr[1:0]};

  // Arbitration: grants only from IDLE and never while reset is asserted.
  always_comb begin
    core_cand   = d_wr_req | d_rd_req;
    in_idle     = (state_q == S_IDLE) && !rst;
    grant_core  = in_idle && core_cand &&
                  (!h_req || (ARB_RR == 0) || (last_grant_q == GRANT_HOST));
    grant_host  = in_idle && h_req && !grant_core;
    rd_core_ret = (state_q == S_RD_CORE) && !rst;
    rd_host_ret = (state_q == S_RD_HOST) && !rst;
  end

  // SRAM port mux, ready generation and next state. A core that raises both
  // write and read gets the write first; the read wins a later arbitration.
  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    m_en    = grant_core | grant_host;
    m_we    = 1'b0;
    m_be    = 4'h0;
    m_addr  = '0;
    m_wdata = 32'h0;
    state_d = S_IDLE;
    if (grant_core) begin
      m_we    = d_wr_req;
      m_be    = d_be;
      m_addr  = d_addr[ADDR_W+1:2];
      m_wdata = d_wr_data;
      if (!d_wr_req) state_d = S_RD_CORE;
    end else if (grant_host) begin
      m_we    = h_we;
      m_be    = h_be;
      m_addr  = h_addr[ADDR_W+1:2];
      m_wdata = h_wdata;
      if (!h_we) state_d = S_RD_HOST;
    end
    d_wr_ready = grant_core && d_wr_req;
    d_rd_ready = rd_core_ret;
    h_ready    = (grant_host && h_we) || rd_host_ret;
    d_rd_data  = rst ? 32'h0 : (rd_core_ret ? m_rdata : d_rd_hold_q);
    h_rdata    = rst ? 32'h0 : (rd_host_ret ? m_rdata : h_rd_hold_q);
  end

  // State, round-robin history and read-data hold registers.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments only.
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= GRANT_HOST;
      d_rd_hold_q  <= 32'h0;
      h_rd_hold_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      if (grant_core)      last_grant_q <= GRANT_CORE;
      else if (grant_host) last_grant_q <= GRANT_HOST;
      if (rd_core_ret) d_rd_hold_q <= m_rdata;
      if (rd_host_ret) h_rd_hold_q <= m_rdata;
    end
  end

`ifdef DMEM_ARB_STAT_EN
  logic [15:0] stat_core_q, stat_host_q;
  logic        core_wait, host_wait;

  // A requester waits when pending, not granted, and not in its own read-return
  // cycle; the grant cycle of a read counts as served.
  always_comb begin
    core_wait = core_cand && !grant_core && (state_q != S_RD_CORE);
    host_wait = h_req && !grant_host && (state_q != S_RD_HOST);
  end

  // Saturating wait counters; clear has priority over increment.
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      stat_core_q <= 16'h0;
      stat_host_q <= 16'h0;
    end else begin
      if (core_wait && (stat_core_q != 16'hFFFF)) stat_core_q <= stat_core_q + 16'd1;
      if (host_wait && (stat_host_q != 16'hFFFF)) stat_host_q <= stat_host_q + 16'd1;
    end
  end

  assign stat_core_wait = stat_core_q;
  assign stat_host_wait = stat_host_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: a round-robin instance driven by a vector table
// plus hand-written sequences, and a fixed-priority instance sharing the inputs.

module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] d_addr = '0, d_wr_data = '0, h_addr = '0, h_wdata = '0;
  logic        d_wr_req = 1'b0, d_rd_req = 1'b0, h_req = 1'b0, h_we = 1'b0;
  logic [3:0]  d_be = '0, h_be = '0;
  logic        stat_clr = 1'b0;

  // Round-robin instance outputs
  logic        d_wr_ready, d_rd_ready, h_ready, m_en, m_we;
  logic [31:0] d_rd_data, h_rdata, m_wdata, m_rdata;
  logic [3:0]  m_be;
  logic [11:0] m_addr;
  logic [15:0] stat_core_wait, stat_host_wait;

  // Fixed-priority instance outputs
  logic        fx_d_wr_ready, fx_d_rd_ready, fx_h_ready, fx_m_en, fx_m_we;
  logic [31:0] fx_d_rd_data, fx_h_rdata, fx_m_wdata, fx_m_rdata;
  logic [3:0]  fx_m_be;
  logic [11:0] fx_m_addr;
  logic [15:0] fx_stat_core_wait, fx_stat_host_wait;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(12), .ARB_RR(1)) dut (
    .clk(clk),
`ifdef DMEM_ARB_STAT_EN
    .stat_clr(stat_clr), .stat_core_wait(stat_core_wait), .stat_host_wait(stat_host_wait),
`endif
    .rst(rst), .d_addr(d_addr), .d_wr_req(d_wr_req), .d_wr_ready(d_wr_ready),
    .d_rd_req(d_rd_req), .d_rd_ready(d_rd_ready), .d_be(d_be), .d_wr_data(d_wr_data),
    .d_rd_data(d_rd_data), .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_be(h_be),
    .h_wdata(h_wdata), .h_ready(h_ready), .h_rdata(h_rdata), .m_en(m_en), .m_we(m_we),
    .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  dmem_arbiter #(.ADDR_W(12), .ARB_RR(0)) dut_fx (
    .clk(clk),
`ifdef DMEM_ARB_STAT_EN
    .stat_clr(stat_clr), .stat_core_wait(fx_stat_core_wait), .stat_host_wait(fx_stat_host_wait),
`endif
    .rst(rst), .d_addr(d_addr), .d_wr_req(d_wr_req), .d_wr_ready(fx_d_wr_ready),
    .d_rd_req(d_rd_req), .d_rd_ready(fx_d_rd_ready), .d_be(d_be), .d_wr_data(d_wr_data),
    .d_rd_data(fx_d_rd_data), .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_be(h_be),
    .h_wdata(h_wdata), .h_ready(fx_h_ready), .h_rdata(fx_h_rdata), .m_en(fx_m_en),
    .m_we(fx_m_we), .m_be(fx_m_be), .m_addr(fx_m_addr), .m_wdata(fx_m_wdata),
    .m_rdata(fx_m_rdata)
  );

`ifndef DMEM_ARB_STAT_EN
  assign stat_core_wait    = 16'h0;
  assign stat_host_wait    = 16'h0;
  assign fx_stat_core_wait = 16'h0;
  assign fx_stat_host_wait = 16'h0;
`endif

  // Byte-enabled synchronous SRAM models, one per instance.
  logic [31:0] mem_rr [0:4095];
  logic [31:0] mem_fx [0:4095];

  always @(posedge clk) begin
    if (m_en) begin
      if (m_we) begin
        for (int b = 0; b < 4; b++)
          if (m_be[b]) mem_rr[m_addr][8*b +: 8] <= m_wdata[8*b +: 8];
      end else begin
        m_rdata <= mem_rr[m_addr];
      end
    end
  end

  always @(posedge clk) begin
    if (fx_m_en) begin
      if (fx_m_we) begin
        for (int b = 0; b < 4; b++)
          if (fx_m_be[b]) mem_fx[fx_m_addr][8*b +: 8] <= fx_m_wdata[8*b +: 8];
      end else begin
        fx_m_rdata <= mem_fx[fx_m_addr];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  typedef struct {
    logic        rst, dw, dr;
    logic [31:0] da;
    logic [3:0]  dbe;
    logic [31:0] dwd;
    logic        hr, hwe;
    logic [31:0] ha;
    logic [3:0]  hbe;
    logic [31:0] hwd;
    logic        en, we;
    logic [11:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        dwr, drr, hrdy;
    logic [31:0] drd, hrd;
  } vec_t;

  function automatic vec_t mk(
    logic r, logic dw, logic dr, logic [31:0] da, logic [3:0] dbe, logic [31:0] dwd,
    logic hr, logic hwe, logic [31:0] ha, logic [3:0] hbe, logic [31:0] hwd,
    logic en, logic we, logic [11:0] addr, logic [3:0] be, logic [31:0] wd,
    logic dwr, logic drr, logic hrdy, logic [31:0] drd, logic [31:0] hrd);
    vec_t v;
    v.rst = r; v.dw = dw; v.dr = dr; v.da = da; v.dbe = dbe; v.dwd = dwd;
    v.hr = hr; v.hwe = hwe; v.ha = ha; v.hbe = hbe; v.hwd = hwd;
    v.en = en; v.we = we; v.addr = addr; v.be = be; v.wd = wd;
    v.dwr = dwr; v.drr = drr; v.hrdy = hrdy; v.drd = drd; v.hrd = hrd;
    return v;
  endfunction

  task automatic idle_inputs();
    d_wr_req = 0; d_rd_req = 0; d_addr = '0; d_be = '0; d_wr_data = '0;
    h_req = 0; h_we = 0; h_addr = '0; h_be = '0; h_wdata = '0;
  endtask

  vec_t vecs[$];

  initial begin
    // rst dw dr d_addr dbe d_wdata | hr hwe h_addr hbe h_wdata | en we addr be wdata | dwr drr hrdy | d_rd_data h_rdata
    vecs.push_back(mk(1,1,0,32'h10,4'hF,32'h0,        1,1,32'h0,4'hF,32'h0,              0,0,12'h0,4'h0,32'h0,        0,0,0, 32'h0,32'h0));
    vecs.push_back(mk(0,1,0,32'h10,4'h3,32'hDEADBEEF, 0,0,32'h0,4'h0,32'h0,              1,1,12'h4,4'h3,32'hDEADBEEF, 1,0,0, 32'h0,32'h0));
    vecs.push_back(mk(0,1,0,32'h10,4'hF,32'h12345678, 0,0,32'h0,4'h0,32'h0,              1,1,12'h4,4'hF,32'h12345678, 1,0,0, 32'h0,32'h0));
    vecs.push_back(mk(0,0,1,32'h10,4'h0,32'h0,        0,0,32'h0,4'h0,32'h0,              1,0,12'h4,4'h0,32'h0,        0,0,0, 32'h0,32'h0));
    vecs.push_back(mk(0,0,1,32'h10,4'h0,32'h0,        1,0,32'h10,4'h0,32'h0,             0,0,12'h0,4'h0,32'h0,        0,1,0, 32'h12345678,32'h0));
    vecs.push_back(mk(0,0,0,32'h0,4'h0,32'h0,         1,0,32'h10,4'h0,32'h0,             1,0,12'h4,4'h0,32'h0,        0,0,0, 32'h12345678,32'h0));
    vecs.push_back(mk(0,0,0,32'h0,4'h0,32'h0,         1,0,32'h10,4'h0,32'h0,             0,0,12'h0,4'h0,32'h0,        0,0,1, 32'h12345678,32'h12345678));
    vecs.push_back(mk(0,0,0,32'h0,4'h0,32'h0,         1,1,32'hFFFFC01B,4'h0,32'hAAAA5555,1,1,12'h6,4'h0,32'hAAAA5555, 0,0,1, 32'h12345678,32'h12345678));
    vecs.push_back(mk(0,1,0,32'h20,4'hF,32'h11111111, 1,1,32'h24,4'hF,32'h22222222,      1,1,12'h8,4'hF,32'h11111111, 1,0,0, 32'h12345678,32'h12345678));
    vecs.push_back(mk(0,1,0,32'h20,4'hF,32'h11111111, 1,1,32'h24,4'hF,32'h22222222,      1,1,12'h9,4'hF,32'h22222222, 0,0,1, 32'h12345678,32'h12345678));
    vecs.push_back(mk(0,1,1,32'h20,4'hF,32'h33333333, 0,0,32'h0,4'h0,32'h0,              1,1,12'h8,4'hF,32'h33333333, 1,0,0, 32'h12345678,32'h12345678));
    vecs.push_back(mk(0,0,1,32'h20,4'h0,32'h0,        0,0,32'h0,4'h0,32'h0,              1,0,12'h8,4'h0,32'h0,        0,0,0, 32'h12345678,32'h12345678));
    vecs.push_back(mk(0,0,1,32'h20,4'h0,32'h0,        0,0,32'h0,4'h0,32'h0,              0,0,12'h0,4'h0,32'h0,        0,1,0, 32'h33333333,32'h12345678));
    vecs.push_back(mk(1,0,0,32'h0,4'h0,32'h0,         0,0,32'h0,4'h0,32'h0,              0,0,12'h0,4'h0,32'h0,        0,0,0, 32'h0,32'h0));
    vecs.push_back(mk(0,0,1,32'h10,4'h0,32'h0,        1,0,32'h24,4'h0,32'h0,             1,0,12'h4,4'h0,32'h0,        0,0,0, 32'h0,32'h0));
    vecs.push_back(mk(0,0,1,32'h10,4'h0,32'h0,        1,0,32'h24,4'h0,32'h0,             0,0,12'h0,4'h0,32'h0,        0,1,0, 32'h12345678,32'h0));
    vecs.push_back(mk(0,0,1,32'h10,4'h0,32'h0,        1,0,32'h24,4'h0,32'h0,             1,0,12'h9,4'h0,32'h0,        0,0,0, 32'h12345678,32'h0));
    vecs.push_back(mk(0,0,1,32'h10,4'h0,32'h0,        1,0,32'h24,4'h0,32'h0,             0,0,12'h0,4'h0,32'h0,        0,0,1, 32'h12345678,32'h22222222));
    vecs.push_back(mk(0,0,1,32'h10,4'h0,32'h0,        1,0,32'h24,4'h0,32'h0,             1,0,12'h4,4'h0,32'h0,        0,0,0, 32'h12345678,32'h22222222));
    vecs.push_back(mk(0,0,1,32'h10,4'h0,32'h0,        0,0,32'h0,4'h0,32'h0,              0,0,12'h0,4'h0,32'h0,        0,1,0, 32'h12345678,32'h22222222));
    vecs.push_back(mk(0,0,0,32'h0,4'h0,32'h0,         1,0,32'h24,4'h0,32'h0,             1,0,12'h9,4'h0,32'h0,        0,0,0, 32'h12345678,32'h22222222));
    vecs.push_back(mk(1,0,0,32'h0,4'h0,32'h0,         1,0,32'h24,4'h0,32'h0,             0,0,12'h0,4'h0,32'h0,        0,0,0, 32'h0,32'h0));
    vecs.push_back(mk(0,0,0,32'h0,4'h0,32'h0,         1,0,32'h24,4'h0,32'h0,             1,0,12'h9,4'h0,32'h0,        0,0,0, 32'h0,32'h0));
    vecs.push_back(mk(0,0,0,32'h0,4'h0,32'h0,         1,0,32'h24,4'h0,32'h0,             0,0,12'h0,4'h0,32'h0,        0,0,1, 32'h0,32'h22222222));
    vecs.push_back(mk(0,0,0,32'h0,4'h0,32'h0,         0,0,32'h0,4'h0,32'h0,              0,0,12'h0,4'h0,32'h0,        0,0,0, 32'h0,32'h22222222));

    idle_inputs();
    repeat (2) @(posedge clk);

    // Table-driven vectors on the round-robin instance.
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      rst = vecs[i].rst;
      d_wr_req = vecs[i].dw; d_rd_req = vecs[i].dr; d_addr = vecs[i].da;
      d_be = vecs[i].dbe; d_wr_data = vecs[i].dwd;
      h_req = vecs[i].hr; h_we = vecs[i].hwe; h_addr = vecs[i].ha;
      h_be = vecs[i].hbe; h_wdata = vecs[i].hwd;
      @(negedge clk);
      check($sformatf("v%0d m_en", i), {31'h0, m_en}, {31'h0, vecs[i].en});
      check($sformatf("v%0d m_we", i), {31'h0, m_we}, {31'h0, vecs[i].we});
      if (vecs[i].en) check($sformatf("v%0d m_addr", i), {20'h0, m_addr}, {20'h0, vecs[i].addr});
      if (vecs[i].en && vecs[i].we) begin
        check($sformatf("v%0d m_be", i), {28'h0, m_be}, {28'h0, vecs[i].be});
        check($sformatf("v%0d m_wdata", i), m_wdata, vecs[i].wd);
      end
      check($sformatf("v%0d d_wr_ready", i), {31'h0, d_wr_ready}, {31'h0, vecs[i].dwr});
      check($sformatf("v%0d d_rd_ready", i), {31'h0, d_rd_ready}, {31'h0, vecs[i].drr});
      check($sformatf("v%0d h_ready", i), {31'h0, h_ready}, {31'h0, vecs[i].hrdy});
      check($sformatf("v%0d d_rd_data", i), d_rd_data, vecs[i].drd);
      check($sformatf("v%0d h_rdata", i), h_rdata, vecs[i].hrd);
    end

    // Fixed priority: continuous core writes starve a pending host read.
    @(posedge clk); #1; idle_inputs(); rst = 1;
    @(posedge clk); #1; rst = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      d_wr_req = 1; d_addr = 32'h40 + 32'(4*k); d_be = 4'hF; d_wr_data = 32'(k);
      h_req = 1; h_we = 0; h_addr = 32'h10;
      @(negedge clk);
      check($sformatf("fx starve%0d h_ready", k), {31'h0, fx_h_ready}, 32'h0);
      check($sformatf("fx starve%0d d_wr_ready", k), {31'h0, fx_d_wr_ready}, 32'h1);
    end
    @(posedge clk); #1; d_wr_req = 0;
    @(negedge clk);
    check("fx host grant m_en", {31'h0, fx_m_en}, 32'h1);
    check("fx host grant m_we", {31'h0, fx_m_we}, 32'h0);
    check("fx host grant h_ready", {31'h0, fx_h_ready}, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("fx host rd h_ready", {31'h0, fx_h_ready}, 32'h1);
    check("fx host rd m_en", {31'h0, fx_m_en}, 32'h0);
    @(posedge clk); #1; idle_inputs();

`ifdef DMEM_ARB_STAT_EN
    // Core stalls behind host: waits in host-read grant, RD_HOST, and host-write win.
    @(posedge clk); #1; rst = 1;
    @(posedge clk); #1; rst = 0;
    d_wr_req = 1; d_addr = 32'h80; d_be = 4'hF; d_wr_data = 32'h5;
    @(posedge clk); #1; h_req = 1; h_we = 0; h_addr = 32'h84;
    @(posedge clk); #1;
    @(posedge clk); #1; h_we = 1; h_be = 4'hF; h_wdata = 32'h6;
    @(posedge clk); #1;
    @(posedge clk); #1; h_req = 0;
    @(posedge clk); #1; idle_inputs();
    @(negedge clk);
    check("stat core wait", {16'h0, stat_core_wait}, 32'd3);
    check("stat host wait", {16'h0, stat_host_wait}, 32'd1);
    @(posedge clk); #1; stat_clr = 1;
    @(posedge clk); #1; stat_clr = 0;
    @(negedge clk);
    check("stat core clr", {16'h0, stat_core_wait}, 32'd0);
    check("stat host clr", {16'h0, stat_host_wait}, 32'd0);

    // Saturation on the fixed-priority instance: host starved by core writes.
    @(posedge clk); #1;
    d_wr_req = 1; d_addr = 32'h100; d_be = 4'hF; d_wr_data = 32'h7;
    h_req = 1; h_we = 0; h_addr = 32'h104;
    repeat (65534) @(posedge clk);
    @(negedge clk);
    check("fx stat host FFFE", {16'h0, fx_stat_host_wait}, 32'h0000FFFE);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("fx stat host sat", {16'h0, fx_stat_host_wait}, 32'h0000FFFF);
    check("fx stat core zero", {16'h0, fx_stat_core_wait}, 32'h0);
    @(posedge clk); #1; idle_inputs();
`endif

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
